mem_sched: RTL and testbench

Byte-serial memory scheduler for the RISC-V core. It shares the single byte-wide RAM port between two requesters: instruction fetch (32-bit word reads) and the memory stage (1/2/4-byte loads and stores). The memory stage has priority, but a bounded-streak rule guarantees that fetch is never starved. It also supports aborting an in-flight fetch on a taken branch. It sits between the IF/MM stages and the external `rom_*` RAM pins.

---
 rtl/mem_sched.sv | 173 +++++++++++++++++
 tb/tb_mem_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sched.sv
// Byte-serial scheduler sharing one byte-wide RAM port between instruction fetch
// and the memory stage, with MM priority bounded by a streak limit and fetch abort.
module mem_sched #(
  parameter int unsigned MAX_MM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_e,
  input  logic [31:0] if_a,
  input  logic        if_kill,
  output logic        if_ok,
  output logic [31:0] if_n,
  input  logic        mm_e,
  input  logic        mm_wr,
  input  logic [31:0] mm_a,
  input  logic [1:0]  mm_cu,
  input  logic [31:0] mm_n_i,
  output logic        mm_ok,
  output logic [31:0] mm_n_o,
  input  logic [7:0]  rom_rn,
  output logic [7:0]  rom_wn,
  output logic [31:0] rom_a,
  output logic        rom_wr
);

  typedef enum logic [2:0] {IDLE, IF_RD, MM_RD, MM_WR, DONE} state_t;

  localparam int unsigned SW = (MAX_MM_STREAK < 2) ? 1 : $clog2(MAX_MM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MM_STREAK);

  state_t        state, state_nx;
  logic [SW-1:0] streak, streak_nx;
  logic [2:0]    cnt, cnt_nx, len, len_nx, cnt_inc;
  logic [1:0]    sidx;
  logic [31:0]   addr, addr_nx, wdata, wdata_nx, rbuf, rbuf_nx;
  logic [7:0]    wbyte;
  logic          if_ok_nx, mm_ok_nx, rom_wr_nx;
  logic [31:0]   if_n_nx, mm_n_o_nx, rom_a_nx;
  logic [7:0]    rom_wn_nx;

  // cnt = cycles spent in the transfer state minus one; byte cnt-1 arrives now
  assign cnt_inc = cnt + 3'd1;
  assign sidx    = cnt[1:0] - 2'd1;

  always_comb begin
    unique case (cnt_inc[1:0])
      2'd0:    wbyte = wdata[7:0];
      2'd1:    wbyte = wdata[15:8];
      2'd2:    wbyte = wdata[23:16];
      default: wbyte = wdata[31:24];
    endcase
  end

  always_comb begin
    state_nx  = state;
    streak_nx = streak;
    cnt_nx    = cnt_inc;
    len_nx    = len;
    addr_nx   = addr;
    wdata_nx  = wdata;
    rbuf_nx   = rbuf;
    if_ok_nx  = 1'b0;
    mm_ok_nx  = 1'b0;
    if_n_nx   = if_n;
    mm_n_o_nx = mm_n_o;
    rom_a_nx  = '0;
    rom_wn_nx = '0;
    rom_wr_nx = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (if_e && (!mm_e || streak == STREAK_MAX)) begin
          state_nx  = IF_RD;
          streak_nx = '0;
          addr_nx   = if_a;
          len_nx    = 3'd4;
          rbuf_nx   = '0;
          rom_a_nx  = if_a;
        end else if (mm_e) begin
          if (!if_e)
            streak_nx = '0;
          else if (streak != STREAK_MAX)
            streak_nx = streak + SW'(1);
          addr_nx  = mm_a;
          wdata_nx = mm_n_i;
          rbuf_nx  = '0;
          rom_a_nx = mm_a;
          unique case (mm_cu)
            2'd0:    len_nx = 3'd1;
            2'd1:    len_nx = 3'd2;
            default: len_nx = 3'd4;
          endcase
          if (mm_wr) begin
            state_nx  = MM_WR;
            rom_wn_nx = mm_n_i[7:0];
            rom_wr_nx = 1'b1;
          end else begin
            state_nx = MM_RD;
          end
        end
      end

      IF_RD, MM_RD: begin
        if (cnt != 3'd0)
          rbuf_nx[{sidx, 3'b000} +: 8] = rom_rn;
        if (state == IF_RD && if_kill) begin
          state_nx = IDLE;
        end else if (cnt == len) begin
          state_nx = DONE;
          if (state == IF_RD) begin
            if_ok_nx = 1'b1;
            if_n_nx  = rbuf_nx;
          end else begin
            mm_ok_nx  = 1'b1;
            mm_n_o_nx = rbuf_nx;
          end
        end else if (cnt_inc < len) begin
          rom_a_nx = addr + {29'd0, cnt_inc};
        end
      end

      MM_WR: begin
        if (cnt_inc < len) begin
          rom_a_nx  = addr + {29'd0, cnt_inc};
          rom_wn_nx = wbyte;
          rom_wr_nx = 1'b1;
        end else begin
          state_nx = DONE;
          mm_ok_nx = 1'b1;
        end
      end

      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      streak <= '0;
      cnt    <= '0;
      len    <= '0;
      addr   <= '0;
      wdata  <= '0;
      rbuf   <= '0;
      if_ok  <= 1'b0;
      mm_ok  <= 1'b0;
      if_n   <= '0;
      mm_n_o <= '0;
      rom_a  <= '0;
      rom_wn <= '0;
      rom_wr <= 1'b0;
    end else begin
      state  <= state_nx;
      streak <= streak_nx;
      cnt    <= cnt_nx;
      len    <= len_nx;
      addr   <= addr_nx;
      wdata  <= wdata_nx;
      rbuf   <= rbuf_nx;
      if_ok  <= if_ok_nx;
      mm_ok  <= mm_ok_nx;
      if_n   <= if_n_nx;
      mm_n_o <= mm_n_o_nx;
      rom_a  <= rom_a_nx;
      rom_wn <= rom_wn_nx;
      rom_wr <= rom_wr_nx;
    end
  end

endmodule

// File: tb/tb_mem_sched.sv
// Scoreboard bench for mem_sched: tests push expected completions/RAM writes,
// independent monitors pop and compare whenever the DUT presents them.
module tb_mem_sched;

  logic        clk, rst;
  logic        if_e, if_kill, if_ok;
  logic [31:0] if_a, if_n;
  logic        mm_e, mm_wr, mm_ok;
  logic [31:0] mm_a, mm_n_i, mm_n_o;
  logic [1:0]  mm_cu;
  logic [7:0]  rom_rn, rom_wn;
  logic [31:0] rom_a;
  logic        rom_wr;

  mem_sched #(.MAX_MM_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_e(if_e), .if_a(if_a), .if_kill(if_kill), .if_ok(if_ok), .if_n(if_n),
    .mm_e(mm_e), .mm_wr(mm_wr), .mm_a(mm_a), .mm_cu(mm_cu), .mm_n_i(mm_n_i),
    .mm_ok(mm_ok), .mm_n_o(mm_n_o),
    .rom_rn(rom_rn), .rom_wn(rom_wn), .rom_a(rom_a), .rom_wr(rom_wr)
  );

  typedef struct {bit is_if; bit chk; logic [31:0] data; int unsigned cyc;} exp_t;
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic wr; logic [31:0] a; logic [1:0] cu; logic [31:0] d;} mreq_t;

  exp_t        exp_q[$];
  wr_t         wr_q[$];
  logic [31:0] if_next[$];
  mreq_t       mm_next[$];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned t0;

  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data one cycle after its address
  always @(posedge clk) begin
    rom_rn <= mem_rd(rom_a);
    if (rom_wr) mem[rom_a] = rom_wn;
  end

  // completion monitor
  always @(negedge clk) begin
    if (if_ok || mm_ok) begin
      checks++;
      if (if_ok && mm_ok) begin
        errors++;
        $display("FAIL ok_excl: if_ok=1 mm_ok=1 at cycle %0d, required one only", cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ok: if_ok=%0b mm_ok=%0b at cycle %0d, required none", if_ok, mm_ok, cyc);
      end else begin
        exp_t e;
        logic [31:0] act;
        e = exp_q.pop_front();
        act = if_ok ? if_n : mm_n_o;
        if (e.is_if != if_ok || e.cyc != cyc || (e.chk && act != e.data)) begin
          errors++;
          $display("FAIL ok_%s: got if_ok=%0b cycle=%0d data=%08h, required if_ok=%0b cycle=%0d data=%08h",
                   e.is_if ? "if" : "mm", if_ok, cyc, act, e.is_if, e.cyc, e.data);
        end
      end
    end
  end

  // RAM write monitor
  always @(negedge clk) begin
    if (rom_wr) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: a=%08h d=%02h at cycle %0d", rom_a, rom_wn, cyc);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        if (w.a != rom_a || w.d != rom_wn) begin
          errors++;
          $display("FAIL ram_write: got a=%08h d=%02h, required a=%08h d=%02h", rom_a, rom_wn, w.a, w.d);
        end
      end
    end
  end

  // requester agent: drop on completion, or present the next queued request
  always @(negedge clk) begin
    if (if_ok) begin
      if (if_next.size() > 0) if_a = if_next.pop_front();
      else if_e = 1'b0;
    end
    if (mm_ok) begin
      if (mm_next.size() > 0) begin
        mreq_t m;
        m = mm_next.pop_front();
        mm_wr = m.wr; mm_a = m.a; mm_cu = m.cu; mm_n_i = m.d;
      end else begin
        mm_e = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end
  endtask

  task automatic exp_ok(input bit is_if, input bit c, input logic [31:0] d, input int unsigned at);
    exp_t e;
    e.is_if = is_if; e.chk = c; e.data = d; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wr_q.push_back(w);
  endtask

  task automatic push_mm(input logic wr, input logic [31:0] a, input logic [1:0] cu, input logic [31:0] d);
    mreq_t m;
    m.wr = wr; m.a = a; m.cu = cu; m.d = d;
    mm_next.push_back(m);
  endtask

  task automatic wait_idle(input int budget);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && wr_q.size() == 0 && !if_e && !mm_e) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d completions and %0d writes outstanding after %0d cycles",
               exp_q.size(), wr_q.size(), budget);
      exp_q.delete(); wr_q.delete(); if_next.delete(); mm_next.delete();
      if_e = 1'b0; mm_e = 1'b0;
    end
  endtask

  task automatic mm_req(input logic wr, input logic [31:0] a, input logic [1:0] cu,
                        input logic [31:0] d, input logic [31:0] rdata, input int unsigned lat);
    @(negedge clk);
    t0 = cyc;
    exp_ok(1'b0, !wr, rdata, t0 + lat);
    mm_wr = wr; mm_a = a; mm_cu = cu; mm_n_i = d; mm_e = 1'b1;
    wait_idle(60);
  endtask

  task automatic fetch_alone();
    @(negedge clk);
    t0 = cyc;
    exp_ok(1'b1, 1'b1, 32'h0010_0513, t0 + 6);
    if_a = 32'h100; if_e = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fetch_rom_a", rom_a, 32'h100 + k);
      chk("fetch_rom_wr", {31'd0, rom_wr}, 32'd0);
    end
    wait_idle(60);
  endtask

  // 4 MM grants while IF waits, then IF, then the remaining MM loads
  task automatic starve();
    @(negedge clk);
    t0 = cyc;
    exp_ok(1'b0, 1'b1, 32'h13, t0 + 3);
    exp_ok(1'b0, 1'b1, 32'h05, t0 + 7);
    exp_ok(1'b0, 1'b1, 32'h10, t0 + 11);
    exp_ok(1'b0, 1'b1, 32'h00, t0 + 15);
    exp_ok(1'b1, 1'b1, 32'h0010_0513, t0 + 22);
    exp_ok(1'b0, 1'b1, 32'h13, t0 + 26);
    exp_ok(1'b0, 1'b1, 32'h05, t0 + 30);
    exp_ok(1'b0, 1'b1, 32'h10, t0 + 34);
    push_mm(1'b0, 32'h101, 2'd0, 32'h0);
    push_mm(1'b0, 32'h102, 2'd0, 32'h0);
    push_mm(1'b0, 32'h103, 2'd0, 32'h0);
    push_mm(1'b0, 32'h100, 2'd0, 32'h0);
    push_mm(1'b0, 32'h101, 2'd0, 32'h0);
    push_mm(1'b0, 32'h102, 2'd0, 32'h0);
    if_a = 32'h100; if_e = 1'b1;
    mm_wr = 1'b0; mm_a = 32'h100; mm_cu = 2'd0; mm_e = 1'b1;
    wait_idle(120);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    if_e = 1'b0; if_a = '0; if_kill = 1'b0;
    mm_e = 1'b0; mm_wr = 1'b0; mm_a = '0; mm_cu = '0; mm_n_i = '0;
    mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h10; mem[32'h103] = 8'h00;
    mem[32'h200] = 8'h04; mem[32'h201] = 8'h03; mem[32'h202] = 8'h02; mem[32'h203] = 8'h01;
    mem[32'h300] = 8'hEF; mem[32'h301] = 8'hBE; mem[32'h302] = 8'hAD; mem[32'h303] = 8'hDE;

    repeat (3) @(negedge clk);
    chk("rst_if_ok", {31'd0, if_ok}, 32'd0);
    chk("rst_mm_ok", {31'd0, mm_ok}, 32'd0);
    chk("rst_if_n", if_n, 32'd0);
    chk("rst_mm_n_o", mm_n_o, 32'd0);
    chk("rst_rom_a", rom_a, 32'd0);
    chk("rst_rom_wn", {24'd0, rom_wn}, 32'd0);
    chk("rst_rom_wr", {31'd0, rom_wr}, 32'd0);
    rst = 1'b1;

    fetch_alone();

    exp_wr(32'h30004, 8'hDD);
    mm_req(1'b1, 32'h30004, 2'd0, 32'hAABB_CCDD, 32'h0, 2);

    exp_wr(32'hFFFF_FFFE, 8'h44);
    exp_wr(32'hFFFF_FFFF, 8'h33);
    exp_wr(32'h0000_0000, 8'h22);
    exp_wr(32'h0000_0001, 8'h11);
    mm_req(1'b1, 32'hFFFF_FFFE, 2'd2, 32'h1122_3344, 32'h0, 5);
    mm_req(1'b0, 32'hFFFF_FFFE, 2'd2, 32'h0, 32'h1122_3344, 6);
    mm_req(1'b0, 32'h100, 2'd3, 32'h0, 32'h0010_0513, 6);
    mm_req(1'b0, 32'h100, 2'd1, 32'h0, 32'h0000_0513, 4);
    mm_req(1'b0, 32'h102, 2'd0, 32'h0, 32'h0000_0010, 3);
    mm_req(1'b0, 32'h30004, 2'd1, 32'h0, 32'h0000_00DD, 4);

    // simultaneous: MM first, IF at the following IDLE
    @(negedge clk);
    t0 = cyc;
    exp_ok(1'b0, 1'b1, 32'h0000_0010, t0 + 4);
    exp_ok(1'b1, 1'b1, 32'h0010_0513, t0 + 11);
    if_a = 32'h100; if_e = 1'b1;
    mm_wr = 1'b0; mm_a = 32'h102; mm_cu = 2'd1; mm_e = 1'b1;
    wait_idle(60);

    starve();

    // kill mid-fetch, then redirect to 0x300
    @(negedge clk);
    t0 = cyc;
    exp_ok(1'b1, 1'b1, 32'hDEAD_BEEF, t0 + 10);
    if_a = 32'h200; if_e = 1'b1;
    repeat (3) @(negedge clk);
    chk("kill_rom_a_c3", rom_a, 32'h202);
    if_kill = 1'b1;
    @(negedge clk);
    if_kill = 1'b0;
    chk("kill_if_n_held", if_n, 32'h0010_0513);
    chk("kill_idle_rom_a", rom_a, 32'h0);
    if_a = 32'h300;
    @(negedge clk);
    chk("kill_new_rom_a", rom_a, 32'h300);
    wait_idle(60);

    // reset during a 4-byte store that was granted with IF waiting
    @(negedge clk);
    t0 = cyc;
    exp_wr(32'h40, 8'h0D);
    exp_wr(32'h41, 8'hF0);
    if_a = 32'h100; if_e = 1'b1;
    mm_wr = 1'b1; mm_a = 32'h40; mm_cu = 2'd2; mm_n_i = 32'hCAFE_F00D; mm_e = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    if_e = 1'b0; mm_e = 1'b0;
    #1;
    chk("rstmid_rom_wr", {31'd0, rom_wr}, 32'd0);
    chk("rstmid_rom_a", rom_a, 32'd0);
    chk("rstmid_mm_ok", {31'd0, mm_ok}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid_no_pending_writes", wr_q.size(), 32'd0);
    fetch_alone();
    starve();

    repeat (3) @(negedge clk);
    chk("final_exp_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
